servo_pwm_multi: RTL

- Multi-channel servo PWM generator: NUM_CH independent pulse outputs share one frame counter.
- Each channel is commanded by angle over a valid/ready port.
- Angle-to-pulse conversion runs in one shared sequential divider.
- Pulse widths update only at frame boundaries, with optional slew-rate limiting.
- Sits between control logic (switch/UART/sensor decoders) and servo header pins; successor to the single-channel fixed-angle servo PWM.

---
 rtl/servo_pwm_multi.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel servo PWM, shared angle-to-width divider
// Define SERVO_SLEW_EN to limit each frame's width change to SLEW_STEP cycles.
module servo_pwm_multi #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 20,
    parameter int PERIOD_CYC = 1000000,
    parameter int MIN_PULSE  = 50000,
    parameter int MAX_PULSE  = 100000,
    parameter int ANGLE_W    = 8,
    parameter int MAX_ANGLE  = 180,
    parameter int SLEW_STEP  = 1000,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CH_W-1:0]    cmd_ch,
    input  logic [ANGLE_W-1:0] cmd_angle,
    input  logic [NUM_CH-1:0]  enable,
    output logic [NUM_CH-1:0]  pwm_out,
    output logic               frame_start
);
    localparam int DW = ANGLE_W + CNT_W;
    localparam int RW = ANGLE_W + 1;
    localparam int SW = RW + 1;
    localparam int BW = $clog2(CNT_W + 1);

    localparam logic [CNT_W-1:0]   PERIOD_M1 = CNT_W'(PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0]   MIN_W     = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0]   STEP_W    = CNT_W'(SLEW_STEP);
    localparam logic [DW-1:0]      RANGE     = DW'(MAX_PULSE - MIN_PULSE);
    localparam logic [ANGLE_W-1:0] MAX_A     = ANGLE_W'(MAX_ANGLE);
    localparam logic [SW-1:0]      MAX_S     = SW'(MAX_ANGLE);
    localparam logic [BW-1:0]      LAST_BIT  = BW'(CNT_W - 1);

    if (NUM_CH < 1 || NUM_CH > 16 || MAX_PULSE >= PERIOD_CYC || MIN_PULSE > MAX_PULSE
        || MAX_ANGLE < 1 || SLEW_STEP < 1) begin : g_bad_cfg
        $error("servo_pwm_multi: illegal parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_WRITE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wrap;
    logic                frame_start_q;
    logic [NUM_CH-1:0]   pwm_q, pwm_d;
    logic [CNT_W-1:0]    target_q [NUM_CH];
    logic [CNT_W-1:0]    active_q [NUM_CH];
    logic [CNT_W-1:0]    active_d [NUM_CH];
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [ANGLE_W-1:0]  angle_q, angle_d;
    logic [RW-1:0]       rem_q, rem_d;
    logic [CNT_W-1:0]    quo_q, quo_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic                wr_en;
    logic [DW-1:0]       prod;
    logic [SW-1:0]       shifted;

    always_comb begin
        wrap  = (cnt_q == PERIOD_M1);
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = enable[i] && (cnt_q < active_q[i]);
`ifdef SERVO_SLEW_EN
            if (target_q[i] > active_q[i]) begin
                active_d[i] = (target_q[i] - active_q[i] <= STEP_W) ? target_q[i]
                                                                     : active_q[i] + STEP_W;
            end else begin
                active_d[i] = (active_q[i] - target_q[i] <= STEP_W) ? target_q[i]
                                                                     : active_q[i] - STEP_W;
            end
`else
            active_d[i] = target_q[i];
`endif
        end
    end

    // Restoring divide: the high ANGLE_W product bits are already < MAX_ANGLE,
    // so they seed the remainder and only CNT_W quotient bits remain to be formed.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        angle_d = angle_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        bit_d   = bit_q;
        wr_en   = 1'b0;
        prod    = DW'(angle_q) * RANGE;
        shifted = {rem_q, quo_q[CNT_W-1]};
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    ch_d    = cmd_ch;
                    angle_d = (cmd_angle > MAX_A) ? MAX_A : cmd_angle;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                rem_d   = {1'b0, prod[DW-1:CNT_W]};
                quo_d   = prod[CNT_W-1:0];
                bit_d   = '0;
                state_d = S_DIV;
            end
            S_DIV: begin
                if (shifted >= MAX_S) begin
                    rem_d = RW'(shifted - MAX_S);
                    quo_d = {quo_q[CNT_W-2:0], 1'b1};
                end else begin
                    rem_d = RW'(shifted);
                    quo_d = {quo_q[CNT_W-2:0], 1'b0};
                end
                bit_d = bit_q + 1'b1;
                if (bit_q == LAST_BIT) state_d = S_WRITE;
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            frame_start_q <= 1'b0;
            pwm_q         <= '0;
            ch_q          <= '0;
            angle_q       <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            bit_q         <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                target_q[i] <= MIN_W;
                active_q[i] <= MIN_W;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            frame_start_q <= wrap;
            pwm_q         <= pwm_d;
            ch_q          <= ch_d;
            angle_q       <= angle_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            bit_q         <= bit_d;
            // Out-of-range channel indices match no i and are dropped here.
            for (int i = 0; i < NUM_CH; i++) begin
                if (wrap) active_q[i] <= active_d[i];
                if (wr_en && ch_q == CH_W'(i)) target_q[i] <= MIN_W + quo_q;
            end
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign pwm_out     = pwm_q;
    assign frame_start = frame_start_q;
endmodule
